// File: rtl/syn_fifo.sv
// rtl/syn_fifo.sv - single-clock FIFO with registered read data and occupancy count
// Pointers carry an extra wrap bit so full and empty are distinguishable without a separate counter.
module syn_fifo #(
  parameter int FIFO_WIDTH = 128,
  parameter int FIFO_DEPTH = 8,
  parameter int FIFO_ADDR  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [FIFO_WIDTH-1:0] data_in,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full,
  output logic [FIFO_ADDR:0]    count
);

  localparam logic [FIFO_ADDR:0] PTR_ONE = {{FIFO_ADDR{1'b0}}, 1'b1};

  logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [FIFO_ADDR:0]    wr_ptr_q, wr_ptr_d;
  logic [FIFO_ADDR:0]    rd_ptr_q, rd_ptr_d;
  logic [FIFO_WIDTH-1:0] data_out_q, data_out_d;
  logic                  wr_accept;
  logic                  rd_accept;

  // Flags depend only on registered pointers, never on the request inputs.
  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[FIFO_ADDR] != rd_ptr_q[FIFO_ADDR]) &&
            (wr_ptr_q[FIFO_ADDR-1:0] == rd_ptr_q[FIFO_ADDR-1:0]);
    count = wr_ptr_q - rd_ptr_q;
  end

  always_comb begin
    wr_accept  = wr_en && !full;
    rd_accept  = rd_en && !empty;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    data_out_d = data_out_q;
    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (rd_accept) begin
      rd_ptr_d   = rd_ptr_q + PTR_ONE;
      data_out_d = mem_q[rd_ptr_q[FIFO_ADDR-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      data_out_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      data_out_q <= data_out_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_accept) begin
      mem_q[wr_ptr_q[FIFO_ADDR-1:0]] <= data_in;
    end
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_syn_fifo.sv
// tb/tb_syn_fifo.sv - randomized and directed bench for syn_fifo against a queue-based model
module tb_syn_fifo;

  localparam int W = 128;
  localparam int D = 8;
  localparam int A = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_en;
  logic         rd_en;
  logic [W-1:0] data_in;
  logic [W-1:0] data_out;
  logic         empty;
  logic         full;
  logic [A:0]   count;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] mq[$];
  logic [W-1:0] m_dout;

  syn_fifo #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .FIFO_ADDR(A)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in),
    .data_out(data_out), .empty(empty), .full(full), .count(count)
  );

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic w, input logic rd, input logic [W-1:0] d);
    int n;
    rst = r; wr_en = w; rd_en = rd; data_in = d;
    @(posedge clk);
    #1;
    n = mq.size();
    if (r) begin
      mq.delete();
      m_dout = '0;
    end else begin
      if (rd && n != 0) m_dout = mq.pop_front();
      if (w && n < D) mq.push_back(d);
    end
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
  endtask

  function automatic logic [W-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic test_reset();
    step(1, 1, 1, 'hFF);
    step(1, 1, 1, 'hFE);
    checks += 4;
    if (data_out !== '0) begin failures++; $display("FAIL reset_data_out got=%0h exp=0", data_out); end
    if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%0b exp=1", empty); end
    if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%0b exp=0", full); end
    if (count !== 0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    step(0, 0, 1, '0);
    checks += 2;
    if (count !== 0) begin failures++; $display("FAIL reset_read_empty_count got=%0d exp=0", count); end
    if (data_out !== '0) begin failures++; $display("FAIL reset_read_empty_dout got=%0h exp=0", data_out); end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      step(0, 1, 0, W'(i));
      checks += 3;
      if (count !== i) begin failures++; $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, count, i); end
      if (empty !== 1'b0) begin failures++; $display("FAIL fill_empty i=%0d got=%0b exp=0", i, empty); end
      if (full !== (i == 8)) begin failures++; $display("FAIL fill_full i=%0d got=%0b exp=%0b", i, full, (i == 8)); end
    end
    step(0, 1, 0, W'(9));
    checks += 2;
    if (count !== 8) begin failures++; $display("FAIL fill_overflow_count got=%0d exp=8", count); end
    if (full !== 1'b1) begin failures++; $display("FAIL fill_overflow_full got=%0b exp=1", full); end
  endtask

  task automatic test_drain();
    int e;
    for (int i = 1; i <= 9; i++) begin
      step(0, 0, 1, '0);
      e = (i <= 8) ? i : 8;
      checks += 3;
      if (data_out !== W'(e)) begin failures++; $display("FAIL drain_data i=%0d got=%0h exp=%0h", i, data_out, e); end
      if (count !== 8 - e) begin failures++; $display("FAIL drain_count i=%0d got=%0d exp=%0d", i, count, 8 - e); end
      if (empty !== (i >= 8)) begin failures++; $display("FAIL drain_empty i=%0d got=%0b exp=%0b", i, empty, (i >= 8)); end
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) step(0, 1, 0, W'(32'h30 + i));
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, '0);
      checks++;
      if (data_out !== W'(32'h30 + i)) begin failures++; $display("FAIL wrap_pre_data i=%0d got=%0h exp=%0h", i, data_out, 32'h30 + i); end
    end
    for (int i = 0; i < 8; i++) step(0, 1, 0, W'(32'hA0 + i));
    checks++;
    if (full !== 1'b1) begin failures++; $display("FAIL wrap_full got=%0b exp=1", full); end
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, '0);
      checks++;
      if (data_out !== W'(32'hA0 + i)) begin failures++; $display("FAIL wrap_order i=%0d got=%0h exp=%0h", i, data_out, 32'hA0 + i); end
    end
    checks++;
    if (empty !== 1'b1) begin failures++; $display("FAIL wrap_empty got=%0b exp=1", empty); end
  endtask

  task automatic test_simultaneous();
    logic [W-1:0] prev;
    prev = data_out;
    step(0, 1, 1, 'h55);
    checks += 2;
    if (count !== 1) begin failures++; $display("FAIL simul_empty_count got=%0d exp=1", count); end
    if (data_out !== prev) begin failures++; $display("FAIL simul_empty_dout got=%0h exp=%0h", data_out, prev); end
    step(0, 1, 1, 'h56);
    checks += 2;
    if (data_out !== W'('h55)) begin failures++; $display("FAIL simul_mid_dout got=%0h exp=55", data_out); end
    if (count !== 1) begin failures++; $display("FAIL simul_mid_count got=%0d exp=1", count); end
    for (int i = 0; i < 7; i++) step(0, 1, 0, rnd_word());
    checks++;
    if (full !== 1'b1) begin failures++; $display("FAIL simul_fill_full got=%0b exp=1", full); end
    step(0, 1, 1, 'hDEAD);
    checks += 2;
    if (count !== 7) begin failures++; $display("FAIL simul_full_count got=%0d exp=7", count); end
    if (data_out !== W'('h56)) begin failures++; $display("FAIL simul_full_dout got=%0h exp=56", data_out); end
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, '0);
      checks++;
      if (data_out !== m_dout) begin failures++; $display("FAIL simul_drain i=%0d got=%0h exp=%0h", i, data_out, m_dout); end
    end
    checks++;
    if (data_out === W'('hDEAD)) begin failures++; $display("FAIL simul_dropped_word got=%0h exp=not_dead", data_out); end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 5; i++) step(0, 1, 0, rnd_word());
    step(0, 0, 1, '0);
    step(0, 1, 0, rnd_word());
    checks++;
    if (count !== 5) begin failures++; $display("FAIL midrst_pre_count got=%0d exp=5", count); end
    step(1, 0, 0, '0);
    checks += 3;
    if (empty !== 1'b1) begin failures++; $display("FAIL midrst_empty got=%0b exp=1", empty); end
    if (count !== 0) begin failures++; $display("FAIL midrst_count got=%0d exp=0", count); end
    if (data_out !== '0) begin failures++; $display("FAIL midrst_dout got=%0h exp=0", data_out); end
    step(0, 1, 0, 'h77);
    step(0, 0, 1, '0);
    checks += 2;
    if (data_out !== W'('h77)) begin failures++; $display("FAIL midrst_after_dout got=%0h exp=77", data_out); end
    if (empty !== 1'b1) begin failures++; $display("FAIL midrst_after_empty got=%0b exp=1", empty); end
  endtask

  task automatic test_random();
    logic r, w, rd;
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 59) == 0);
      w  = ($urandom_range(0, 99) < 55);
      rd = ($urandom_range(0, 99) < 50);
      step(r, w, rd, rnd_word());
      checks += 4;
      if (data_out !== m_dout) begin failures++; $display("FAIL rand_dout i=%0d got=%0h exp=%0h", i, data_out, m_dout); end
      if (count !== mq.size()) begin failures++; $display("FAIL rand_count i=%0d got=%0d exp=%0d", i, count, mq.size()); end
      if (empty !== (mq.size() == 0)) begin failures++; $display("FAIL rand_empty i=%0d got=%0b exp=%0b", i, empty, (mq.size() == 0)); end
      if (full !== (mq.size() == D)) begin failures++; $display("FAIL rand_full i=%0d got=%0b exp=%0b", i, full, (mq.size() == D)); end
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; data_in = '0; m_dout = '0;
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simultaneous();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
